// File: rtl/cordic_phase_feeder.sv
// Phase accumulator and quadrant-reduction front end for an iterative CORDIC sin/cos core.
// Issues one core conversion per sample and publishes the sign flags for the downstream fix-up.
module cordic_phase_feeder #(
    parameter int unsigned PHASE_W = 10,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic               CLK,
    input  logic               RESET_PULSE,
    input  logic               EN,
    input  logic [PHASE_W-1:0] FREQ_WORD,
    input  logic               CORDIC_DONE,
    output logic [7:0]         ANGLE_OUT,
    output logic               CORDIC_START,
    output logic               SIN_NEG,
    output logic               COS_NEG,
    output logic [PHASE_W-1:0] PHASE_OUT,
    output logic               TAG_VALID,
    output logic               ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_pend_phase;
    logic               r_pend_sneg;
    logic               r_pend_cneg;
    logic [7:0]         r_cnt;
    logic [7:0]         r_angle;
    logic               r_sin_neg;
    logic               r_cos_neg;
    logic [PHASE_W-1:0] r_phase_out;
    logic               r_tag_valid;
    logic               r_err;

    logic [1:0]         w_quad;
    logic [7:0]         w_frac;
    logic [7:0]         w_angle;
    logic               w_sneg;
    logic               w_cneg;
    logic               w_capture;
    logic               w_done;
    logic               w_timeout;

    // Odd quadrants mirror the fraction; bits below the top 8 are simply dropped.
    assign w_quad  = r_phase[PHASE_W-1 -: 2];
    assign w_frac  = r_phase[PHASE_W-3 -: 8];
    assign w_angle = w_quad[0] ? ~w_frac : w_frac;
    assign w_sneg  = w_quad[1];
    assign w_cneg  = w_quad[1] ^ w_quad[0];

    assign w_capture = (r_state == ST_IDLE) && EN;
    assign w_done    = (r_state == ST_WAIT) && CORDIC_DONE;
    assign w_timeout = (r_state == ST_WAIT) && !CORDIC_DONE && (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RESET_PULSE) begin
        if (!RESET_PULSE) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (EN) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (CORDIC_DONE || w_timeout) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_PULSE) begin
        if (!RESET_PULSE) begin
            r_phase      <= '0;
            r_pend_phase <= '0;
            r_pend_sneg  <= 1'b0;
            r_pend_cneg  <= 1'b0;
            r_cnt        <= '0;
            r_angle      <= '0;
            r_sin_neg    <= 1'b0;
            r_cos_neg    <= 1'b0;
            r_phase_out  <= '0;
            r_tag_valid  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_tag_valid <= w_done;
            if (w_capture) begin
                r_angle      <= w_angle;
                r_pend_sneg  <= w_sneg;
                r_pend_cneg  <= w_cneg;
                r_pend_phase <= r_phase;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !CORDIC_DONE && !w_timeout) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Phase advances only on a completed sample; a timeout retries the same phase.
            if (w_done) begin
                r_sin_neg   <= r_pend_sneg;
                r_cos_neg   <= r_pend_cneg;
                r_phase_out <= r_pend_phase;
                r_phase     <= r_phase + FREQ_WORD;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ANGLE_OUT    = r_angle;
    assign CORDIC_START = (r_state == ST_ISSUE);
    assign SIN_NEG      = r_sin_neg;
    assign COS_NEG      = r_cos_neg;
    assign PHASE_OUT    = r_phase_out;
    assign TAG_VALID    = r_tag_valid;
    assign ERR          = r_err;

endmodule
